// File: rtl/dot_pkg.sv
// Shared types and constants for the dot-product accelerator:
// sequencer states, CPU register offsets and the fixed-point format.
package dot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ_W,
        WAIT_W,
        REQ_X,
        WAIT_X,
        MAC
    } state_e;

    localparam logic [3:0] REG_START = 4'd0;
    localparam logic [3:0] REG_WADDR = 4'd1;
    localparam logic [3:0] REG_XADDR = 4'd2;
    localparam logic [3:0] REG_LEN   = 4'd3;

    localparam int FRAC_BITS = 16;

endpackage

// File: rtl/dot_product_if.sv
// Bus bundle for the accelerator: the CPU-facing Avalon-MM slave port and
// the SDRAM-facing Avalon-MM read master port.
interface dot_product_if;

    logic        slave_waitrequest;
    logic [3:0]  slave_address;
    logic        slave_read;
    logic [31:0] slave_readdata;
    logic        slave_write;
    logic [31:0] slave_writedata;

    logic        master_waitrequest;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        master_write;
    logic [31:0] master_writedata;

    // master: the accelerator's view; slave: the view of the CPU and memory around it.
    modport master (
        output slave_waitrequest, slave_readdata,
        output master_address, master_read, master_write, master_writedata,
        input  slave_address, slave_read, slave_write, slave_writedata,
        input  master_waitrequest, master_readdata, master_readdatavalid
    );

    modport slave (
        input  slave_waitrequest, slave_readdata,
        input  master_address, master_read, master_write, master_writedata,
        output slave_address, slave_read, slave_write, slave_writedata,
        output master_waitrequest, master_readdata, master_readdatavalid
    );

endinterface

// File: rtl/fixmul.sv
// Combinational signed Q16.16 multiply: full 64-bit product, arithmetic
// shift by the fraction width, keep the low 32 bits (wraps, no saturation).
module fixmul
    import dot_pkg::*;
(
    input  logic signed [31:0] a,
    input  logic signed [31:0] b,
    output logic signed [31:0] y
);

    logic signed [63:0] prod;

    assign prod = 64'(a) * 64'(b);
    assign y    = 32'(prod >>> FRAC_BITS);

endmodule

// File: rtl/dot_product.sv
// Avalon-MM dot-product accelerator: fetches W[i] and X[i] one read at a
// time from memory and accumulates their Q16.16 products into one result.
module dot_product
    import dot_pkg::*;
(
    input logic           clk,
    input logic           rst_n,
    dot_product_if.master bus
);

    state_e      state_q, state_d;
    logic [31:0] w_base_q, w_base_d, x_base_q, x_base_d, len_q, len_d;
    logic [31:0] run_w_q, run_w_d, run_x_q, run_x_d, run_len_q, run_len_d;
    logic [31:0] idx_q, idx_d, acc_q, acc_d, result_q, result_d;
    logic [31:0] w_q, w_d, x_q, x_d;
    logic [31:0] product;

    fixmul u_fixmul (
        .a (w_q),
        .b (x_q),
        .y (product)
    );

    always_comb begin
        // NOTE: every _d gets its hold value first so no path infers a latch.
        state_d   = state_q;
        w_base_d  = w_base_q;
        x_base_d  = x_base_q;
        len_d     = len_q;
        run_w_d   = run_w_q;
        run_x_d   = run_x_q;
        run_len_d = run_len_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        result_d  = result_q;
        w_d       = w_q;
        x_d       = x_q;

        case (state_q)
            IDLE: begin
                if (bus.slave_write) begin
                    case (bus.slave_address)
                        REG_START: begin
                            // The run works from a private copy of the setup registers.
                            run_w_d   = w_base_q;
                            run_x_d   = x_base_q;
                            run_len_d = len_q;
                            idx_d     = '0;
                            acc_d     = '0;
                            if (len_q == '0) result_d = '0;
                            else             state_d  = REQ_W;
                        end
                        REG_WADDR: w_base_d = bus.slave_writedata;
                        REG_XADDR: x_base_d = bus.slave_writedata;
                        REG_LEN:   len_d    = bus.slave_writedata;
                        default: ;
                    endcase
                end
            end
            REQ_W:  if (!bus.master_waitrequest) state_d = WAIT_W;
            WAIT_W: begin
                if (bus.master_readdatavalid) begin
                    w_d     = bus.master_readdata;
                    state_d = REQ_X;
                end
            end
            REQ_X:  if (!bus.master_waitrequest) state_d = WAIT_X;
            WAIT_X: begin
                if (bus.master_readdatavalid) begin
                    x_d     = bus.master_readdata;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + product;
                if (idx_q + 32'd1 < run_len_q) begin
                    idx_d   = idx_q + 32'd1;
                    state_d = REQ_W;
                end else begin
                    result_d = acc_q + product;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            w_base_q  <= '0;
            x_base_q  <= '0;
            len_q     <= '0;
            run_w_q   <= '0;
            run_x_q   <= '0;
            run_len_q <= '0;
            idx_q     <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            w_q       <= '0;
            x_q       <= '0;
        end else begin
            state_q   <= state_d;
            w_base_q  <= w_base_d;
            x_base_q  <= x_base_d;
            len_q     <= len_d;
            run_w_q   <= run_w_d;
            run_x_q   <= run_x_d;
            run_len_q <= run_len_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            w_q       <= w_d;
            x_q       <= x_d;
        end
    end

    always_comb begin
        bus.slave_readdata = '0;
        case (bus.slave_address)
            REG_START: bus.slave_readdata = result_q;
            REG_WADDR: bus.slave_readdata = w_base_q;
            REG_XADDR: bus.slave_readdata = x_base_q;
            REG_LEN:   bus.slave_readdata = len_q;
            default: ;
        endcase
    end

    // CPU accesses only complete in IDLE, so a result read blocks until the run ends.
    assign bus.slave_waitrequest = (state_q != IDLE) && (bus.slave_read || bus.slave_write);

    // Request outputs decode straight from state, so they hold while the slave stalls.
    always_comb begin
        bus.master_address = '0;
        if (state_q == REQ_W) bus.master_address = run_w_q + (idx_q << 2);
        if (state_q == REQ_X) bus.master_address = run_x_q + (idx_q << 2);
    end

    assign bus.master_read      = (state_q == REQ_W) || (state_q == REQ_X);
    assign bus.master_write     = 1'b0;
    assign bus.master_writedata = '0;

endmodule

// File: tb/tb_dot_product.sv
// Self-checking bench for dot_product: CPU bus tasks, a memory responder with
// random stalls/latency, an address monitor, and a reference dot-product model.
module tb_dot_product;
    import dot_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dot_product_if bus ();

    dot_product dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bit [31:0]   mem [bit [31:0]];
    logic [31:0] exp_addr [$];
    logic [31:0] wv [$];
    logic [31:0] xv [$];

    int stall_fix    = 0;   // -1 selects a random stall per request
    int lat_fix      = 0;   // -1 selects a random response latency
    bit drop_resp    = 1'b0;
    bit inject_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got 0x%08h, expected no such event", name, act);
    endtask

    // Reference: sum of floor(W*X / 2^16) over the bench's own memory, wrapped to 32 bits.
    function automatic logic [31:0] model_dot(input logic [31:0] wb, input logic [31:0] xb,
                                              input int len);
        logic [31:0] acc = '0;
        longint      p;
        for (int i = 0; i < len; i++) begin
            p   = longint'($signed(mem[wb + 32'(4 * i)])) * longint'($signed(mem[xb + 32'(4 * i)]));
            acc = acc + 32'(p >>> 16);
        end
        return acc;
    endfunction

    // Memory: stalls each request, then returns one readdatavalid beat.
    initial begin : responder
        int          wcnt, stall_n, resp_cnt;
        bit          in_req, resp_due;
        logic [31:0] resp_addr;
        wcnt = 0; stall_n = 0; resp_cnt = 0; in_req = 0; resp_due = 0; resp_addr = '0;
        bus.master_waitrequest   = 1'b0;
        bus.master_readdatavalid = 1'b0;
        bus.master_readdata      = '0;
        forever begin
            @(negedge clk);
            bus.master_readdatavalid = 1'b0;
            bus.master_readdata      = $urandom;
            if (inject_valid) begin
                bus.master_readdatavalid = 1'b1;
                inject_valid = 1'b0;
            end else if (resp_due) begin
                if (resp_cnt == 0) begin
                    resp_due = 1'b0;
                    if (!drop_resp) begin
                        bus.master_readdatavalid = 1'b1;
                        bus.master_readdata = mem.exists(resp_addr) ? mem[resp_addr] : 32'h0;
                    end
                end else begin
                    resp_cnt--;
                end
            end
            if (bus.master_read) begin
                if (!in_req) begin
                    in_req  = 1'b1;
                    wcnt    = 0;
                    stall_n = (stall_fix >= 0) ? stall_fix : int'($urandom_range(0, 2));
                end
                if (wcnt < stall_n) begin
                    bus.master_waitrequest = 1'b1;
                    wcnt++;
                end else begin
                    bus.master_waitrequest = 1'b0;
                    in_req    = 1'b0;
                    resp_due  = 1'b1;
                    resp_addr = bus.master_address;
                    resp_cnt  = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 2));
                end
            end else begin
                bus.master_waitrequest = 1'b0;
                in_req = 1'b0;
            end
        end
    end

    // Compare process: accepted read addresses in order, stable requests under stall.
    initial begin : monitor
        logic [31:0] held_addr;
        bit          held;
        held = 1'b0;
        held_addr = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("stall_read_held", {31'b0, bus.master_read}, 32'd1);
                    check("stall_addr_held", bus.master_address, held_addr);
                end
                held = 1'b0;
                if (bus.master_read) begin
                    check("master_write_low", {31'b0, bus.master_write}, 32'd0);
                    if (bus.master_waitrequest) begin
                        held      = 1'b1;
                        held_addr = bus.master_address;
                    end else if (exp_addr.size() == 0) begin
                        fail_now("unexpected_read", bus.master_address);
                    end else begin
                        check("read_addr", bus.master_address, exp_addr.pop_front());
                    end
                end
            end
        end
    end

    task automatic cpu_write(input logic [3:0] a, input logic [31:0] d, output int waits);
        @(negedge clk);
        bus.slave_address   = a;
        bus.slave_writedata = d;
        bus.slave_write     = 1'b1;
        #1;
        waits = 0;
        while (bus.slave_waitrequest && waits < 2000) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (waits >= 2000) fail_now("write_timeout", 32'(waits));
        @(posedge clk);
        #1;
        bus.slave_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [31:0] d, output int waits);
        @(negedge clk);
        bus.slave_address = a;
        bus.slave_read    = 1'b1;
        #1;
        waits = 0;
        while (bus.slave_waitrequest && waits < 2000) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (waits >= 2000) fail_now("read_timeout", 32'(waits));
        d = bus.slave_readdata;
        @(posedge clk);
        #1;
        bus.slave_read = 1'b0;
    endtask

    // Load vectors into memory, queue the expected read addresses, program regs 1-3.
    task automatic prep(input logic [31:0] wb, input logic [31:0] xb, input int len);
        int w;
        for (int i = 0; i < len; i++) begin
            mem[wb + 32'(4 * i)] = wv[i];
            mem[xb + 32'(4 * i)] = xv[i];
        end
        for (int i = 0; i < len; i++) begin
            exp_addr.push_back(wb + 32'(4 * i));
            exp_addr.push_back(xb + 32'(4 * i));
        end
        cpu_write(REG_WADDR, wb, w);
        cpu_write(REG_XADDR, xb, w);
        cpu_write(REG_LEN, 32'(len), w);
    endtask

    function automatic logic [31:0] rand_q();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 1) == 1) v = 32'($signed(v) >>> 12);
        return v;
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] r, exp, wb, xb;
        int          waits, w, len;

        bus.slave_address   = '0;
        bus.slave_read      = 1'b0;
        bus.slave_write     = 1'b0;
        bus.slave_writedata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst_master_read", {31'b0, bus.master_read}, 32'd0);
        check("rst_master_addr", bus.master_address, 32'd0);
        for (int a = 0; a < 4; a++) begin
            cpu_read(4'(a), r, waits);
            check($sformatf("rst_reg%0d", a), r, 32'd0);
            check($sformatf("rst_reg%0d_waits", a), 32'(waits), 32'd0);
        end

        // Two-element run; result read issued right after start blocks 2 x 5 cycles
        wv = '{32'h0001_0000, 32'h0002_0000};
        xv = '{32'h0003_0000, 32'h0000_8000};
        prep(32'h1000, 32'h2000, 2);
        check("basic_model", model_dot(32'h1000, 32'h2000, 2), 32'h0004_0000);
        cpu_read(REG_WADDR, r, waits); check("basic_reg_w", r, 32'h1000);
        cpu_read(REG_XADDR, r, waits); check("basic_reg_x", r, 32'h2000);
        cpu_read(REG_LEN, r, waits);   check("basic_reg_len", r, 32'd2);
        cpu_write(REG_START, '0, w);
        cpu_read(REG_START, r, waits);
        check("basic_result", r, 32'h0004_0000);
        check("basic_busy_cycles", 32'(waits), 32'd10);
        check("basic_all_reads", 32'(exp_addr.size()), 32'd0);

        // Negative operand
        wv = '{32'hFFFE_8000};
        xv = '{32'h0002_0000};
        prep(32'h3000, 32'h4000, 1);
        check("neg_model", model_dot(32'h3000, 32'h4000, 1), 32'hFFFD_0000);
        cpu_write(REG_START, '0, w);
        cpu_read(REG_START, r, waits);
        check("neg_result", r, 32'hFFFD_0000);

        // Zero length: no bus traffic, immediate zero result
        cpu_write(REG_LEN, 32'd0, w);
        cpu_write(REG_START, '0, w);
        cpu_read(REG_START, r, waits);
        check("len0_result", r, 32'd0);
        check("len0_waits", 32'(waits), 32'd0);
        check("len0_no_read", {31'b0, bus.master_read}, 32'd0);

        // Three-cycle slave stall on every request
        stall_fix = 3;
        wv = '{32'h0001_0000, 32'h0002_0000};
        xv = '{32'h0003_0000, 32'h0000_8000};
        prep(32'h1000, 32'h2000, 2);
        cpu_write(REG_START, '0, w);
        cpu_read(REG_START, r, waits);
        check("stall_result", r, 32'h0004_0000);
        check("stall_all_reads", 32'(exp_addr.size()), 32'd0);
        stall_fix = 0;

        // Length write while busy is stalled and leaves the run alone
        prep(32'h1000, 32'h2000, 2);
        cpu_write(REG_START, '0, w);
        cpu_write(REG_LEN, 32'd5, waits);
        check("busy_write_stalled", {31'b0, waits > 0}, 32'd1);
        cpu_read(REG_START, r, waits);
        check("busy_write_result", r, 32'h0004_0000);
        cpu_read(REG_LEN, r, waits);
        check("busy_write_len", r, 32'd5);
        check("busy_write_reads", 32'(exp_addr.size()), 32'd0);

        // Randomized runs with random stalls, latencies and bases (incl. wrap at 2^32)
        stall_fix = -1;
        lat_fix   = -1;
        for (int t = 0; t < 20; t++) begin
            len = int'($urandom_range(1, 6));
            wb  = (t % 5 == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            xb  = $urandom & 32'hFFFF_FFFC;
            wv.delete();
            xv.delete();
            for (int i = 0; i < len; i++) begin
                wv.push_back(rand_q());
                xv.push_back(rand_q());
            end
            prep(wb, xb, len);
            exp = model_dot(wb, xb, len);
            cpu_write(REG_START, '0, w);
            cpu_read(REG_START, r, waits);
            check($sformatf("rand%0d_result", t), r, exp);
            check($sformatf("rand%0d_reads", t), 32'(exp_addr.size()), 32'd0);
        end
        stall_fix = 0;
        lat_fix   = 0;

        // Reset while waiting for X, followed by a stale readdatavalid
        wv = '{32'h0001_0000};
        xv = '{32'h0005_0000};
        prep(32'h5000, 32'h6000, 1);
        cpu_write(REG_START, '0, w);
        w = 0;
        do begin
            @(negedge clk);
            #3;
            w++;
        end while (!(bus.master_read && bus.master_address == 32'h6000) && w < 50);
        if (w >= 50) fail_now("rst_x_request_timeout", 32'(w));
        drop_resp = 1'b1;
        @(negedge clk);
        #3;
        rst_n        = 1'b0;
        inject_valid = 1'b1;
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        #3;
        drop_resp = 1'b0;
        check("midrst_master_read", {31'b0, bus.master_read}, 32'd0);
        check("midrst_master_addr", bus.master_address, 32'd0);
        cpu_read(REG_START, r, waits);
        check("midrst_result", r, 32'd0);
        check("midrst_idle", 32'(waits), 32'd0);
        cpu_read(REG_WADDR, r, waits);
        check("midrst_reg_w", r, 32'd0);
        cpu_read(REG_LEN, r, waits);
        check("midrst_reg_len", r, 32'd0);
        repeat (4) @(negedge clk);
        check("midrst_still_idle", {31'b0, bus.master_read}, 32'd0);
        check("midrst_reads", 32'(exp_addr.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
